// File: rtl/conv_mac_engine.sv
// Sequential KxK convolution MAC: LANES multipliers per cycle, full-width accumulation,
// round-half-up and saturation to DATA_W. Optional input bias via `define CONV_BIAS_EN.
module conv_mac_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11,
  parameter int K      = 5,
  parameter int LANES  = 5,
  parameter int ACC_W  = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K*K*DATA_W-1:0]     window,
  input  logic [K*K*DATA_W-1:0]     filter,
`ifdef CONV_BIAS_EN
  input  logic [DATA_W-1:0]         bias,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         conv_result,
  output logic                      overflow
);

  localparam int TAPS  = K * K;
  localparam int C     = (TAPS + LANES - 1) / LANES;
  localparam int IDX_W = (C * LANES > 1) ? $clog2(C * LANES) : 1;
  localparam int PAD   = 1 << IDX_W;
  localparam int ROUND = 1 << (FRAC_W - 1);

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_NORM, S_DONE} state_t;

  state_t                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [IDX_W-1:0]          idx_q;
  logic [TAPS*DATA_W-1:0]    win_q;
  logic [TAPS*DATA_W-1:0]    flt_q;

  logic signed [DATA_W-1:0]   win_pad [PAD];
  logic signed [DATA_W-1:0]   flt_pad [PAD];
  logic [IDX_W-1:0]           tap;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    lane_sum;
  logic signed [ACC_W:0]      bias_term;
  logic signed [ACC_W:0]      norm_sum;
  logic signed [ACC_W:0]      norm_shift;
  logic [DATA_W-1:0]          sat_result;
  logic                       sat_flag;

  wire capture = (state_q == S_IDLE) && start;

  // NOTE: operand registers have no reset; they are only read after a capture writes them.
  always_ff @(posedge clk) begin
    if (capture) begin
      win_q <= window;
      flt_q <= filter;
    end
  end

`ifdef CONV_BIAS_EN
  logic [DATA_W-1:0] bias_q;
  always_ff @(posedge clk) begin
    if (capture) bias_q <= bias;
  end
  assign bias_term = (ACC_W+1)'($signed(bias_q)) <<< FRAC_W;
`else
  assign bias_term = '0;
`endif

  // Zero-padded tap view: lanes running past the last tap multiply zeros.
  always_comb begin
    win_pad = '{default: '0};
    flt_pad = '{default: '0};
    for (int i = 0; i < TAPS; i++) begin
      win_pad[i] = win_q[i*DATA_W +: DATA_W];
      flt_pad[i] = flt_q[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane_sum = '0;
    tap      = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      tap      = idx_q + IDX_W'(l);
      prod     = win_pad[tap] * flt_pad[tap];
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    norm_sum   = (ACC_W+1)'(acc_q) + bias_term + (ACC_W+1)'(ROUND);
    norm_shift = norm_sum >>> FRAC_W;
    sat_flag   = 1'b0;
    sat_result = norm_shift[DATA_W-1:0];
    if (norm_shift > SAT_MAX) begin
      sat_result = {1'b0, {(DATA_W-1){1'b1}}};
      sat_flag   = 1'b1;
    end else if (norm_shift < SAT_MIN) begin
      sat_result = {1'b1, {(DATA_W-1){1'b0}}};
      sat_flag   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      conv_result <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + lane_sum;
          idx_q <= idx_q + IDX_W'(LANES);
          if (idx_q == IDX_W'((C - 1) * LANES)) state_q <= S_NORM;
        end
        S_NORM: begin
          conv_result <= sat_result;
          overflow    <= sat_flag;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed and randomised checks of conv_mac_engine with LANES = 5, 1, 4, 25 side by side
// against hand-computed values and a behavioural reference.
module tb_conv_mac_engine;

  localparam int DW   = 16;
  localparam int TAPS = 25;
  localparam int ND   = 4;
  localparam int LANES_TAB [ND] = '{5, 1, 4, 25};
  localparam int LAT_TAB   [ND] = '{7, 27, 9, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [TAPS*DW-1:0] window = '0;
  logic [TAPS*DW-1:0] filter = '0;

  logic [ND-1:0] busy_v, done_v, ovf_v;
  logic [DW-1:0] res_v [ND];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_engine #(.LANES(5)) u_l5 (.clk(clk), .rst_n(rst_n), .start(start), .window(window),
    .filter(filter), .busy(busy_v[0]), .done(done_v[0]), .conv_result(res_v[0]), .overflow(ovf_v[0]));
  conv_mac_engine #(.LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .start(start), .window(window),
    .filter(filter), .busy(busy_v[1]), .done(done_v[1]), .conv_result(res_v[1]), .overflow(ovf_v[1]));
  conv_mac_engine #(.LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .start(start), .window(window),
    .filter(filter), .busy(busy_v[2]), .done(done_v[2]), .conv_result(res_v[2]), .overflow(ovf_v[2]));
  conv_mac_engine #(.LANES(25)) u_l25 (.clk(clk), .rst_n(rst_n), .start(start), .window(window),
    .filter(filter), .busy(busy_v[3]), .done(done_v[3]), .conv_result(res_v[3]), .overflow(ovf_v[3]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cap;
  int first_lat [ND];
  int second_lat [ND];
  int ndone [ND];
  logic [DW-1:0] got_res [ND];
  logic got_ovf [ND];

  task automatic clear_rec();
    for (int d = 0; d < ND; d++) begin
      first_lat[d] = -1; second_lat[d] = -1; ndone[d] = 0;
      got_res[d] = 'x; got_ovf[d] = 1'bx;
    end
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (done_v[d]) begin
          if (ndone[d] == 0) begin
            first_lat[d] = cyc - cap;
            got_res[d]   = res_v[d];
            got_ovf[d]   = ovf_v[d];
          end else if (ndone[d] == 1) begin
            second_lat[d] = cyc - cap;
          end
          ndone[d]++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    clear_rec();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cap = cyc;
  endtask

  function automatic logic [TAPS*DW-1:0] splat(input logic [DW-1:0] v);
    logic [TAPS*DW-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Reference: exact integer sum, round half up, shift, saturate.
  function automatic logic [DW:0] ref_conv(input logic [TAPS*DW-1:0] w, input logic [TAPS*DW-1:0] f);
    longint s = 0;
    logic [DW-1:0] a, b;
    for (int i = 0; i < TAPS; i++) begin
      a = w[i*DW +: DW];
      b = f[i*DW +: DW];
      s += longint'($signed(a)) * longint'($signed(b));
    end
    s = (s + 1024) >>> 11;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  task automatic run_vec(input string tag, input logic [TAPS*DW-1:0] w,
                         input logic [TAPS*DW-1:0] f, input logic [DW-1:0] exp_res, input logic exp_ovf);
    window = w;
    filter = f;
    pulse_start();
    check({tag, "_busy"}, 32'(busy_v), 32'hF);
    watch(32);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_res_l%0d", tag, LANES_TAB[d]), 32'(got_res[d]), 32'(exp_res));
      check($sformatf("%s_ovf_l%0d", tag, LANES_TAB[d]), 32'(got_ovf[d]), 32'(exp_ovf));
      check($sformatf("%s_lat_l%0d", tag, LANES_TAB[d]), 32'(first_lat[d]), 32'(LAT_TAB[d]));
      check($sformatf("%s_ndone_l%0d", tag, LANES_TAB[d]), 32'(ndone[d]), 32'd1);
    end
  endtask

  initial begin
    logic [TAPS*DW-1:0] w, f;
    logic [DW:0] r;

    clear_rec();
    cap = 0;
    #3;
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_res0", 32'(res_v[0]), 32'h0);
    check("rst_ovf", 32'(ovf_v), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(3);
    check("idle_no_done", 32'(ndone[0] + ndone[1] + ndone[2] + ndone[3]), 32'd0);

    f = '0;
    f[12*DW +: DW] = 16'h1000;
    run_vec("center", splat(16'h0800), f, 16'h1000, 1'b0);
    run_vec("neg_sum", splat(16'h0800), splat(16'hFF00), 16'hE700, 1'b0);
    run_vec("sat_pos", splat(16'h0800), splat(16'h0800), 16'h7FFF, 1'b1);
    run_vec("sat_neg", splat(16'hF800), splat(16'h0800), 16'h8000, 1'b1);
    w = '0; f = '0;
    w[15:0] = 16'h0001; f[15:0] = 16'h0400;
    run_vec("round_up", w, f, 16'h0001, 1'b0);
    w[15:0] = 16'hFFFF;
    run_vec("round_neg", w, f, 16'h0000, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < TAPS; i++) begin
        if (k == 5) begin
          w[i*DW +: DW] = 16'($urandom());
          f[i*DW +: DW] = 16'($urandom());
        end else begin
          w[i*DW +: DW] = 16'($urandom_range(0, 2047) - 1024);
          f[i*DW +: DW] = 16'($urandom_range(0, 2047) - 1024);
        end
      end
      r = ref_conv(w, f);
      run_vec($sformatf("rand%0d", k), w, f, r[DW-1:0], r[DW]);
    end

    // start pulsed again while busy must be ignored
    window = splat(16'h0800);
    filter = splat(16'hFF00);
    pulse_start();
    watch(1);
    start = 1'b1;
    watch(1);
    start = 1'b0;
    watch(40);
    for (int d = 0; d < ND; d++)
      check($sformatf("busy_start_ndone_l%0d", LANES_TAB[d]), 32'(ndone[d]), 32'd1);

    // start held high: one capture per return to IDLE
    clear_rec();
    @(negedge clk);
    start = 1'b1;
    cap = cyc + 1;
    watch(60);
    start = 1'b0;
    watch(40);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("b2b_first_l%0d", LANES_TAB[d]), 32'(first_lat[d]), 32'(LAT_TAB[d]));
      check($sformatf("b2b_period_l%0d", LANES_TAB[d]), 32'(second_lat[d] - first_lat[d]),
            32'(LAT_TAB[d] + 1));
    end

    // reset in the middle of an operation
    window = splat(16'h0800);
    filter = splat(16'hFF00);
    pulse_start();
    watch(2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_v), 32'h0);
    check("midrst_done", 32'(done_v), 32'h0);
    for (int d = 0; d < ND; d++)
      check($sformatf("midrst_res_l%0d", LANES_TAB[d]), 32'(res_v[d]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_rec();
    watch(40);
    check("midrst_no_done", 32'(ndone[0] + ndone[1] + ndone[2] + ndone[3]), 32'd0);
    check("midrst_idle_busy", 32'(busy_v), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Sequential, parametrised KxK convolution MAC for the CNN datapath; one window/filter pair in, one signed fixed-point output pixel out.
- Time-multiplexes LANES signed multipliers over K*K taps, accumulates at full width, then rounds and saturates to DATA_W.
- Uses a start/busy/done handshake, so the feature-map controller can stream windows back to back.

Parameters:
- DATA_W, 16: operand and result width, two's complement fixed point.
- FRAC_W, 11: fraction bits of operands and result (default Q5.11).
- K, 5: kernel side; K*K taps.
- LANES, 5: multipliers used per MAC cycle; 1 <= LANES <= K*K.
- ACC_W, 40: accumulator width; must be >= 2*DATA_W + clog2(K*K).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  request; sampled only in IDLE
- window  in  K*K*DATA_W  taps, tap i at bits [i*DATA_W +: DATA_W], row-major
- filter  in  K*K*DATA_W  weights, same packing
- busy  out  1  high from the capture edge until done is asserted
- done  out  1  one-cycle pulse; conv_result valid
- conv_result  out  DATA_W  rounded, saturated sum of products
- overflow  out  1  saturation occurred for this result; valid with done

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, conv_result=0, overflow=0, accumulator=0.
- States and transitions:
  - IDLE: when start=1, capture window and filter into internal registers, clear the accumulator, clear the tap index, go to MAC, busy=1.
  - MAC: each cycle, multiply taps idx..idx+LANES-1 and add them to the accumulator; idx += LANES.
    - Lanes with idx >= K*K contribute 0.
    - Leave for NORM after C = ceil(K*K/LANES) cycles.
  - NORM: add 2^(FRAC_W-1) to the accumulator (round half up), then arithmetic-shift right by FRAC_W.
    - If the result is above 2^(DATA_W-1)-1: conv_result = 0x7FF..F, overflow=1.
    - If the result is below -2^(DATA_W-1): conv_result = 0x800..0, overflow=1.
    - Otherwise conv_result = the truncated value, overflow=0.
    - Go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0, then go to IDLE.
- Latency: done is high in the cycle C+2 clocks after the edge that sampled start. Default C=5, so 7 cycles.
- Throughput: one result per C+3 cycles. start may already be high in the cycle after DONE.
- Arithmetic:
  - Products are full 2*DATA_W signed and are sign-extended to ACC_W.
  - The accumulator never wraps for legal ACC_W.
- Output holding: conv_result and overflow hold their value until the next NORM. done never asserts without a preceding capture.
- Input timing: start while busy is ignored and not queued. window and filter may change freely after the capture edge.
- start held high continuously: a new capture occurs on each return to IDLE.
- Reset mid-operation: the operation is aborted immediately, all outputs return to reset values, and no done is produced.

Optional Feature:
- Macro CONV_BIAS_EN.
- When defined:
  - Adds input port bias, DATA_W wide, same Q format, captured with window.
  - In NORM, bias sign-extended and shifted left by FRAC_W is added to the accumulator before rounding.
  - Saturation applies to the biased sum.
- When undefined: no bias port, and behaviour is as above with an implicit bias of 0.

Test Plan:
- Reset then idle: rst_n low mid-MAC -> busy=0, done=0, conv_result=0x0000, and no done pulse after release.
- Window all 0x0800, filter center tap 0x1000, rest 0 -> done at cycle 7, conv_result=0x1000, overflow=0.
- Window all 0x0800, filter all 0xFF00 -> conv_result=0xE700 (-3.125), overflow=0.
- Window all 0x0800, filter all 0x0800 (sum 25.0) -> conv_result=0x7FFF, overflow=1. All 0xF800 x 0x0800 (sum -25.0) -> conv_result=0x8000, overflow=1.
- Rounding: tap0 0x0001 x 0x0400, rest 0 -> conv_result=0x0001. Tap0 0xFFFF x 0x0400 -> conv_result=0x0000.
- Parameter sweep, LANES=1, 4, 25 with random operands against a reference model -> bit-exact results and done at C+2 (27, 9, 3). start pulsed while busy -> no extra done. Back-to-back starts -> one done per C+3 cycles.
